pc_ret_stack: RTL and testbench

- Return-address stack that sits directly upstream of the program counter.
- On a CALL, the core pushes the current PC address, which is already the address after the call.
- On a RETURN, the core pops, and dout drives the PC load data so execution resumes after the call.
- Hardware LIFO with full/empty status and sticky error flags for stack misuse.

---
 rtl/pc_ret_stack.sv | 114 +++++++++++
 tb/tb_pc_ret_stack.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pc_ret_stack.sv
// Return-address LIFO feeding the PC load port on CALL/RETURN.
// dout is registered so the pop cycle already sees the return address.
module pc_ret_stack #(
   parameter int NBITS = 8,
   parameter int SDEPT = 8,
   parameter int CBITS = $clog2(SDEPT+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [NBITS-1:0] din,
   output logic [NBITS-1:0] dout,
   output logic [CBITS-1:0] cnt,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   localparam int AW = (SDEPT > 1) ? $clog2(SDEPT) : 1;

   logic [NBITS-1:0] r_mem [SDEPT];
   logic [NBITS-1:0] r_dout;
   logic [CBITS-1:0] r_cnt;
   logic             r_ovf;
   logic             r_unf;

   logic             w_empty;
   logic             w_full;
   logic             w_one;
   logic [AW-1:0]    w_idx_push;
   logic [AW-1:0]    w_idx_top;
   logic [AW-1:0]    w_idx_below;
   logic             w_we;
   logic [AW-1:0]    w_waddr;
   logic             w_live;

   assign w_empty     = (r_cnt == '0);
   assign w_full      = (r_cnt == CBITS'(SDEPT));
   assign w_one       = (r_cnt == CBITS'(1));
   assign w_idx_push  = AW'(r_cnt);
   assign w_idx_top   = AW'(r_cnt - CBITS'(1));
   assign w_idx_below = AW'(r_cnt - CBITS'(2));
   assign w_live      = rst && !flush;

   // Same-cycle push+pop overwrites the top, or acts as a plain push when empty.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = w_idx_push;
      if (w_live && push) begin
         if (pop && !w_empty) begin
            w_we    = 1'b1;
            w_waddr = w_idx_top;
         end else if (pop || !w_full) begin
            w_we    = 1'b1;
            w_waddr = w_idx_push;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= din;
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         r_cnt  <= '0;
         r_dout <= '0;
         r_ovf  <= 1'b0;
         r_unf  <= 1'b0;
      end else if (push && pop) begin
         r_dout <= din;
         if (w_empty) r_cnt <= CBITS'(1);
      end else if (push) begin
         if (w_full) begin
            r_ovf <= 1'b1;
         end else begin
            r_cnt  <= r_cnt + CBITS'(1);
            r_dout <= din;
         end
      end else if (pop) begin
         if (w_empty) begin
            r_unf <= 1'b1;
         end else if (w_one) begin
            r_cnt  <= '0;
            r_dout <= '0;
         end else begin
            r_cnt  <= r_cnt - CBITS'(1);
            r_dout <= r_mem[w_idx_below];
         end
      end
   end

`ifdef __ICARUS__
   logic r_ovf_q;
   logic r_unf_q;
   always_ff @(posedge clk) begin
      r_ovf_q <= r_ovf;
      r_unf_q <= r_unf;
      if (r_ovf && !r_ovf_q) $display("pc_ret_stack: warning, stack overflow");
      if (r_unf && !r_unf_q) $display("pc_ret_stack: warning, stack underflow");
   end
`endif

   assign dout  = r_dout;
   assign cnt   = r_cnt;
   assign empty = w_empty;
   assign full  = w_full;
   assign ovf   = r_ovf;
   assign unf   = r_unf;

endmodule

// File: tb/tb_pc_ret_stack.sv
// Bench for pc_ret_stack: directed call/return scenarios plus random
// traffic against a queue-based model of the return stack.
module tb_pc_ret_stack;

   localparam int NBITS = 8;
   localparam int SDEPT = 8;
   localparam int CBITS = $clog2(SDEPT+1);

   logic             clk = 1'b0;
   logic             rst;
   logic             push;
   logic             pop;
   logic             flush;
   logic [NBITS-1:0] din;
   logic [NBITS-1:0] dout;
   logic [CBITS-1:0] cnt;
   logic             empty;
   logic             full;
   logic             ovf;
   logic             unf;

   int n_cmp = 0;
   int n_err = 0;

   logic [NBITS-1:0] m_stk[$];
   logic [NBITS-1:0] m_dout;
   logic             m_ovf;
   logic             m_unf;

   pc_ret_stack #(.NBITS(NBITS), .SDEPT(SDEPT)) dut (
      .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
      .din(din), .dout(dout), .cnt(cnt), .empty(empty), .full(full),
      .ovf(ovf), .unf(unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model(input logic r, input logic ps, input logic pp,
                        input logic fl, input logic [NBITS-1:0] d);
      if (!r || fl) begin
         m_stk.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else if (ps && pp) begin
         if (m_stk.size() == 0) m_stk.push_back(d);
         else m_stk[m_stk.size()-1] = d;
         m_dout = d;
      end else if (ps) begin
         if (m_stk.size() == SDEPT) m_ovf = 1'b1;
         else begin
            m_stk.push_back(d);
            m_dout = d;
         end
      end else if (pp) begin
         if (m_stk.size() == 0) m_unf = 1'b1;
         else begin
            void'(m_stk.pop_back());
            m_dout = (m_stk.size() == 0) ? '0 : m_stk[m_stk.size()-1];
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".cnt"},   32'(cnt),   32'(m_stk.size()));
      chk({tag, ".dout"},  32'(dout),  32'(m_dout));
      chk({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
      chk({tag, ".full"},  32'(full),  32'(m_stk.size() == SDEPT));
      chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
      chk({tag, ".unf"},   32'(unf),   32'(m_unf));
   endtask

   task automatic step(input string tag, input logic r, input logic ps,
                       input logic pp, input logic fl,
                       input logic [NBITS-1:0] d);
      @(negedge clk);
      rst = r; push = ps; pop = pp; flush = fl; din = d;
      @(posedge clk);
      model(r, ps, pp, fl, d);
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; din = '0;
      m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;

      step("rst0", 0, 0, 0, 0, 8'h00);
      step("rst1", 0, 0, 0, 0, 8'h00);
      step("idle", 1, 0, 0, 0, 8'h00);
      chk("idle.cnt0", 32'(cnt), 32'd0);
      chk("idle.empty1", 32'(empty), 32'd1);

      step("lifo.p10", 1, 1, 0, 0, 8'h10);
      step("lifo.p20", 1, 1, 0, 0, 8'h20);
      step("lifo.p30", 1, 1, 0, 0, 8'h30);
      chk("lifo.top", 32'(dout), 32'h30);
      chk("lifo.cnt3", 32'(cnt), 32'd3);
      step("lifo.pop1", 1, 0, 1, 0, 8'h00);
      chk("lifo.d20", 32'(dout), 32'h20);
      step("lifo.pop2", 1, 0, 1, 0, 8'h00);
      chk("lifo.d10", 32'(dout), 32'h10);
      step("lifo.pop3", 1, 0, 1, 0, 8'h00);
      chk("lifo.d00", 32'(dout), 32'h00);
      chk("lifo.empty", 32'(empty), 32'd1);

      for (int i = 1; i <= 8; i++) step("fill", 1, 1, 0, 0, 8'(i));
      chk("fill.full", 32'(full), 32'd1);
      chk("fill.top", 32'(dout), 32'h08);
      step("ovf.p09", 1, 1, 0, 0, 8'h09);
      chk("ovf.flag", 32'(ovf), 32'd1);
      chk("ovf.cnt", 32'(cnt), 32'd8);
      chk("ovf.top", 32'(dout), 32'h08);
      for (int i = 7; i >= 0; i--) begin
         step("drain", 1, 0, 1, 0, 8'h00);
         chk("drain.dout", 32'(dout), 32'(i));
      end
      chk("drain.ovf", 32'(ovf), 32'd1);

      step("unf.pop", 1, 0, 1, 0, 8'h00);
      chk("unf.flag", 32'(unf), 32'd1);
      step("rep.p44", 1, 1, 0, 0, 8'h44);
      step("rep.pp55", 1, 1, 1, 0, 8'h55);
      chk("rep.dout", 32'(dout), 32'h55);
      chk("rep.cnt", 32'(cnt), 32'd1);
      step("rep.pop", 1, 0, 1, 0, 8'h00);
      step("epp.66", 1, 1, 1, 0, 8'h66);
      chk("epp.dout", 32'(dout), 32'h66);
      chk("epp.cnt", 32'(cnt), 32'd1);

      step("fl.clr", 1, 0, 0, 1, 8'h00);
      step("fl.p11", 1, 1, 0, 0, 8'h11);
      step("fl.p22", 1, 1, 0, 0, 8'h22);
      for (int i = 0; i < 7; i++) step("fl.fill", 1, 1, 0, 0, 8'(8'h30 + i));
      chk("fl.ovf", 32'(ovf), 32'd1);
      step("fl.flushpush", 1, 1, 0, 1, 8'h77);
      chk("fl.cnt", 32'(cnt), 32'd0);
      chk("fl.ovf0", 32'(ovf), 32'd0);
      step("fl.p88", 1, 1, 0, 0, 8'h88);
      step("rst.push", 0, 1, 0, 0, 8'h99);
      chk("rst.cnt", 32'(cnt), 32'd0);
      step("rst.after", 1, 1, 0, 0, 8'hA1);
      step("rst.pop", 1, 0, 1, 0, 8'h00);
      chk("rst.dout0", 32'(dout), 32'h00);

      step("call1", 1, 1, 0, 0, 8'h06);
      step("call2", 1, 1, 0, 0, 8'h13);
      chk("ret1.load", 32'(dout), 32'h13);
      step("ret1", 1, 0, 1, 0, 8'h00);
      chk("ret2.load", 32'(dout), 32'h06);
      step("ret2", 1, 0, 1, 0, 8'h00);

      for (int i = 0; i < 600; i++) begin
         int unsigned bias;
         int unsigned rn;
         logic ps, pp, fl, r;
         bias = (i / 100) % 3;
         rn = $urandom_range(99);
         r  = ($urandom_range(199) != 0);
         fl = ($urandom_range(79) == 0);
         if (bias == 0) begin
            ps = (rn < 65); pp = ($urandom_range(99) < 30);
         end else if (bias == 1) begin
            ps = (rn < 30); pp = ($urandom_range(99) < 65);
         end else begin
            ps = (rn < 50); pp = ($urandom_range(99) < 50);
         end
         step("rand", r, ps, pp, fl, 8'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
